// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg: shared state type and constants for fifo_wr_arbiter.
package fifo_wr_arb_pkg;
   typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
   localparam int STAT_W = 16;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: rotating-priority picker; returns the first set req bit at or after start, wrapping at N.
module rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx
);
   int j;
   always_comb begin
      found = 1'b0;
      idx = '0;
      j = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(start) + i;
         j = j >= N ? j - N : j;
         if (req[j] && !found) begin
            found = 1'b1;
            idx = W'(j);
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin bounded-burst arbiter driving a FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add saturating beat/stall counters with stat_clr.
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int GNT_W      = $clog2(NUM_REQ),
   parameter int BEAT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
`ifdef FIFO_WR_ARB_STATS_EN
   input  logic                          stat_clr,
   output logic [STAT_W-1:0]             stat_beats,
   output logic [STAT_W-1:0]             stat_stalls,
`endif
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_din,
   output logic [NUM_REQ-1:0]            gnt_onehot,
   output logic                          busy
);
   arb_state_t        state_q, state_d;
   logic [GNT_W-1:0]  gnt_idx_q, gnt_idx_d, rr_ptr_q, rr_ptr_d, pick_idx, rr_next;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic              pick_found, cur_valid, accept;
   logic [NUM_REQ-1:0] gnt_vec;

   rr_pick #(.N(NUM_REQ), .W(GNT_W)) u_pick (
      .req(req_valid), .start(rr_ptr_q), .found(pick_found), .idx(pick_idx)
   );

   // Outputs are gated by rst so a burst cut by reset never writes in the reset cycle.
   always_comb begin
      busy       = state_q == ARB_BURST;
      gnt_vec    = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_q;
      cur_valid  = req_valid[gnt_idx_q];
      accept     = busy && cur_valid && !fifo_full && !rst;
      gnt_onehot = busy ? gnt_vec : '0;
      req_ready  = (busy && !fifo_full && !rst) ? gnt_vec : '0;
      fifo_wr_en = accept;
      fifo_din   = (busy && !rst) ? req_data[gnt_idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
      rr_next    = gnt_idx_q == GNT_W'(NUM_REQ - 1) ? '0 : gnt_idx_q + 1'b1;
   end

   always_comb begin
      state_d    = state_q;
      gnt_idx_d  = gnt_idx_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      if (!busy) begin
         if (pick_found) begin
            state_d    = ARB_BURST;
            gnt_idx_d  = pick_idx;
            beat_cnt_d = '0;
         end
      end else begin
         if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
         if ((accept && beat_cnt_q == BEAT_W'(MAX_BURST - 1)) || !cur_valid) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = rr_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         gnt_idx_q  <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         gnt_idx_q  <= gnt_idx_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [STAT_W-1:0] stat_beats_q, stat_beats_d, stat_stalls_q, stat_stalls_d;
   always_comb begin
      stat_beats_d  = stat_clr ? '0 : stat_beats_q + STAT_W'(accept && !(&stat_beats_q));
      stat_stalls_d = stat_clr ? '0 : stat_stalls_q + STAT_W'(busy && cur_valid && fifo_full && !(&stat_stalls_q));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_beats_q  <= '0;
         stat_stalls_q <= '0;
      end else begin
         stat_beats_q  <= stat_beats_d;
         stat_stalls_q <= stat_stalls_d;
      end
   end
   assign stat_beats  = stat_beats_q;
   assign stat_stalls = stat_stalls_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios; expected writes queued at stimulus time, checked by a monitor.
module tb_fifo_wr_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic        fifo_full = 1'b0;
   logic        fifo_wr_en;
   logic [7:0]  fifo_din;
   logic [3:0]  gnt_onehot;
   logic        busy;
`ifdef FIFO_WR_ARB_STATS_EN
   logic        stat_clr = 1'b0;
   logic [15:0] stat_beats, stat_stalls;
`endif

   int total = 0;
   int bad = 0;
   logic [3:0]  en = '0;
   logic [7:0]  src[4][$];
   logic [11:0] exp_q[$];
   logic [11:0] mon_e;

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
`ifdef FIFO_WR_ARB_STATS_EN
      .stat_clr(stat_clr), .stat_beats(stat_beats), .stat_stalls(stat_stalls),
`endif
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
      .gnt_onehot(gnt_onehot), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic feed(input int r, input logic [7:0] d, input logic [3:0] g);
      src[r].push_back(d);
      exp_q.push_back({g, d});
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         req_valid[i] = en[i] && src[i].size() > 0;
         req_data[i*8 +: 8] = req_valid[i] ? src[i][0] : 8'h00;
      end
   endtask

   // One clock: present inputs, check grant/write at negedge, retire accepted items.
   task automatic cyc(input logic [3:0] eg, input logic ew);
      logic [3:0] acc;
      drive();
      @(negedge clk);
      chk("grant", gnt_onehot, eg);
      chk("busy", busy, |eg);
      chk("wr_en", fifo_wr_en, ew);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (acc[i]) void'(src[i].pop_front());
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      en = '0;
      for (int i = 0; i < 4; i++) src[i].delete();
      drive();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (fifo_wr_en) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_write: din=%0h gnt=%0h, none expected", fifo_din, gnt_onehot);
         end else begin
            mon_e = exp_q.pop_front();
            chk("din", fifo_din, mon_e[7:0]);
            chk("wr_gnt", gnt_onehot, mon_e[11:8]);
            chk("write_while_full", fifo_full, 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset held 3 cycles with random inputs.
      for (int c = 0; c < 3; c++) begin
         req_valid = 4'($urandom);
         req_data = $urandom;
         fifo_full = 1'($urandom);
         @(negedge clk);
         chk("rst_gnt", gnt_onehot, 0);
         chk("rst_busy", busy, 0);
         chk("rst_wr_en", fifo_wr_en, 0);
         chk("rst_ready", req_ready, 0);
         chk("rst_din", fifo_din, 0);
         @(posedge clk);
         #1;
      end
      fifo_full = 1'b0;
      rst = 1'b0;

      // Only req 2: two bursts split by one bubble.
      for (int k = 0; k < 6; k++) feed(2, 8'(8'h20 + k), 4'b0100);
      en = 4'b0100;
      cyc(4'b0000, 0);
      repeat (4) cyc(4'b0100, 1);
      cyc(4'b0000, 0);
      repeat (2) cyc(4'b0100, 1);
      cyc(4'b0100, 0);
      cyc(4'b0000, 0);

      // All four continuously valid: grants 0,1,2,3,0.
      rst_pulse();
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 8; k++) src[r].push_back(8'(r * 16 + k));
      for (int g = 0; g < 5; g++)
         for (int k = 0; k < 4; k++) exp_q.push_back({4'(1 << (g % 4)), 8'((g % 4) * 16 + (g / 4) * 4 + k)});
      en = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         cyc(4'b0000, 0);
         repeat (4) cyc(4'(1 << (g % 4)), 1);
      end
      en = '0;
      for (int i = 0; i < 4; i++) src[i].delete();
      cyc(4'b0000, 0);

      // Req 1 with a 3-cycle fifo_full stall after beat 2.
      rst_pulse();
      for (int k = 0; k < 4; k++) feed(1, 8'(8'h40 + k), 4'b0010);
      en = 4'b0010;
      cyc(4'b0000, 0);
      repeat (2) cyc(4'b0010, 1);
      fifo_full = 1'b1;
      repeat (3) cyc(4'b0010, 0);
      fifo_full = 1'b0;
      repeat (2) cyc(4'b0010, 1);
      cyc(4'b0000, 0);
`ifdef FIFO_WR_ARB_STATS_EN
      chk("stat_beats", stat_beats, 4);
      chk("stat_stalls", stat_stalls, 3);
      stat_clr = 1'b1;
      cyc(4'b0000, 0);
      stat_clr = 1'b0;
      chk("stat_beats_clr", stat_beats, 0);
      chk("stat_stalls_clr", stat_stalls, 0);
`endif

      // Req 3 drops after 2 beats; req 0 granted next via wrap.
      for (int k = 0; k < 2; k++) feed(3, 8'(8'h50 + k), 4'b1000);
      src[3].push_back(8'h52);
      for (int k = 0; k < 2; k++) feed(0, 8'(8'h60 + k), 4'b0001);
      en = 4'b1000;
      cyc(4'b0000, 0);
      cyc(4'b1000, 1);
      en = 4'b1001;
      cyc(4'b1000, 1);
      en = 4'b0001;
      cyc(4'b1000, 0);
      cyc(4'b0000, 0);
      repeat (2) cyc(4'b0001, 1);
      cyc(4'b0001, 0);
      cyc(4'b0000, 0);
      src[3].delete();

      // Reset mid-burst on req 1; afterwards scan restarts at req 0.
      for (int k = 0; k < 2; k++) feed(1, 8'(8'h70 + k), 4'b0010);
      en = 4'b0010;
      src[1].push_back(8'h72);
      src[1].push_back(8'h73);
      cyc(4'b0000, 0);
      repeat (2) cyc(4'b0010, 1);
      rst = 1'b1;
      en = 4'b0011;
      for (int k = 0; k < 4; k++) feed(0, 8'(8'h80 + k), 4'b0001);
      exp_q.push_back({4'b0010, 8'h72});
      exp_q.push_back({4'b0010, 8'h73});
      drive();
      @(negedge clk);
      chk("rst_mid_wr_en", fifo_wr_en, 0);
      chk("rst_mid_ready", req_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(4'b0000, 0);
      repeat (4) cyc(4'b0001, 1);
      cyc(4'b0000, 0);
      repeat (2) cyc(4'b0010, 1);
      cyc(4'b0010, 0);
      en = '0;
      cyc(4'b0000, 0);

      chk("leftover_expected", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
